transmision_dac: RTL and testbench



---
 rtl/dac_pkg.sv | 10 +
 rtl/dac_bit_timer.sv | 62 ++++++
 rtl/transmision_dac.sv | 65 ++++++
 tb/tb_transmision_dac.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/dac_pkg.sv
// Shared constants and types for the serial DAC transmitter.
package dac_pkg;

  localparam int unsigned DAC_DATA_WIDTH   = 24;
  localparam int unsigned DAC_CLKS_PER_BIT = 2;
  localparam int unsigned DAC_FRAME_CLKS   = DAC_DATA_WIDTH * DAC_CLKS_PER_BIT;

  typedef logic [DAC_DATA_WIDTH-1:0] dac_sample_t;

endpackage

// File: rtl/dac_bit_timer.sv
// Phase/bit counters for the serial DAC transmitter.
// Produces the frame_start and bit_advance strobes.
// Optional macro TRANSMISION_FRAME_SYNC_EN adds the clk_high output, which is
// the serial bit clock level.
module dac_bit_timer
  import dac_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DAC_DATA_WIDTH,
  parameter int unsigned CLKS_PER_BIT = DAC_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset,
  output logic frame_start,
  output logic bit_advance
`ifdef TRANSMISION_FRAME_SYNC_EN
  ,
  output logic clk_high
`endif
);

  localparam int unsigned PW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BW   = $clog2(DATA_WIDTH);
  localparam int unsigned HALF = CLKS_PER_BIT / 2;

  logic [PW-1:0] phase;
  logic [BW-1:0] bit_cnt;
  logic          load_pending;
  logic          phase_last;
  logic          bit_last;

  assign phase_last  = (phase == PW'(CLKS_PER_BIT - 1));
  assign bit_last    = (bit_cnt == BW'(DATA_WIDTH - 1));
  // After reset the first free edge loads; afterwards the last clock of bit 0 rolls into a reload.
  assign frame_start = load_pending | (phase_last & bit_last);
  assign bit_advance = ~load_pending & phase_last & ~bit_last;

`ifdef TRANSMISION_FRAME_SYNC_EN
  // Low for the first HALF clocks of each bit period; held low while no frame is running.
  assign clk_high = ~load_pending & (phase >= PW'(HALF));
`endif

  // Phase counter wraps every bit period; bit counter wraps every frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase        <= '0;
      bit_cnt      <= '0;
      load_pending <= 1'b1;
    end else begin
      load_pending <= 1'b0;
      if (frame_start) begin
        phase   <= '0;
        bit_cnt <= '0;
      end else if (phase_last) begin
        phase   <= '0;
        bit_cnt <= bit_cnt + 1'b1;
      end else begin
        phase <= phase + 1'b1;
      end
    end
  end

endmodule

// File: rtl/transmision_dac.sv
// Parallel-to-serial transmitter for a serial-input audio DAC.
// Sends DATA_WIDTH-bit samples MSB-first, CLKS_PER_BIT clocks per bit, no gaps.
// Optional macro TRANSMISION_FRAME_SYNC_EN adds the FrameSync and SerialClk outputs.
module transmision_dac
  import dac_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DAC_DATA_WIDTH,
  parameter int unsigned CLKS_PER_BIT = DAC_CLKS_PER_BIT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] dataAConvertir,
  output logic                  DataOut
`ifdef TRANSMISION_FRAME_SYNC_EN
  ,
  output logic                  FrameSync,
  output logic                  SerialClk
`endif
);

  logic                  frame_start;
  logic                  bit_advance;
  // The MSB goes straight to DataOut on load, so only the remaining bits are kept here.
  logic [DATA_WIDTH-2:0] shift_reg;

  dac_bit_timer #(
    .DATA_WIDTH  (DATA_WIDTH),
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .frame_start(frame_start),
    .bit_advance(bit_advance)
`ifdef TRANSMISION_FRAME_SYNC_EN
    ,
    .clk_high   (SerialClk)
`endif
  );

  // Load a new sample at frame start, otherwise shift one bit per bit period.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_reg <= '0;
      DataOut   <= 1'b0;
    end else if (frame_start) begin
      shift_reg <= dataAConvertir[DATA_WIDTH-2:0];
      DataOut   <= dataAConvertir[DATA_WIDTH-1];
    end else if (bit_advance) begin
      shift_reg <= {shift_reg[DATA_WIDTH-3:0], 1'b0};
      DataOut   <= shift_reg[DATA_WIDTH-2];
    end
  end

`ifdef TRANSMISION_FRAME_SYNC_EN
  // Frame marker: high during the first clock of each frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      FrameSync <= 1'b0;
    end else begin
      FrameSync <= frame_start;
    end
  end
`endif

endmodule

// File: tb/tb_transmision_dac.sv
// Self-checking bench for transmision_dac: per-frame scoreboard of expected serial bits.
module tb_transmision_dac;
  import dac_pkg::*;

  localparam int unsigned DW  = DAC_DATA_WIDTH;
  localparam int unsigned CPB = DAC_CLKS_PER_BIT;
  localparam int unsigned FC  = DAC_FRAME_CLKS;

  logic        clk = 1'b0;
  logic        reset;
  dac_sample_t data;
  logic        data_out;
`ifdef TRANSMISION_FRAME_SYNC_EN
  logic        frame_sync;
  logic        serial_clk;
`endif

  int tests  = 0;
  int fails  = 0;
  bit exp_q[$];

  transmision_dac #(
    .DATA_WIDTH  (DW),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .dataAConvertir(data),
    .DataOut       (data_out)
`ifdef TRANSMISION_FRAME_SYNC_EN
    ,
    .FrameSync     (frame_sync),
    .SerialClk     (serial_clk)
`endif
  );

  always #5 clk = ~clk;

  // Queue the expected serial pattern of one frame carrying w.
  task automatic push_frame(input dac_sample_t w);
    for (int i = 0; i < int'(FC); i++) exp_q.push_back(w[DW - 1 - i / CPB]);
  endtask

  // Check one clock of a running frame at position i.
  task automatic check_cycle(input string name, input int i);
    bit e;
    e = exp_q.pop_front();
    tests++;
    if (data_out !== e) begin
      fails++;
      $display("FAIL %s cycle %0d: DataOut=%b expected %b", name, i, data_out, e);
    end
`ifdef TRANSMISION_FRAME_SYNC_EN
    tests++;
    if (frame_sync !== (i == 0)) begin
      fails++;
      $display("FAIL %s_sync cycle %0d: FrameSync=%b expected %b", name, i, frame_sync, (i == 0));
    end
    tests++;
    if (serial_clk !== ((i % CPB) >= (CPB / 2))) begin
      fails++;
      $display("FAIL %s_sclk cycle %0d: SerialClk=%b expected %b", name, i, serial_clk,
               ((i % CPB) >= (CPB / 2)));
    end
`endif
  endtask

  // Called just before a frame-start edge; optionally changes the input mid-frame.
  task automatic send_frame(input string name, input dac_sample_t w,
                            input int change_at, input dac_sample_t w2);
    data = w;
    push_frame(w);
    for (int i = 0; i < int'(FC); i++) begin
      @(posedge clk); #1;
      check_cycle(name, i);
      if (i == change_at) data = w2;
    end
  endtask

  task automatic check_idle(input string name);
    tests++;
    if (data_out !== 1'b0) begin
      fails++;
      $display("FAIL %s: DataOut=%b expected 0", name, data_out);
    end
`ifdef TRANSMISION_FRAME_SYNC_EN
    tests++;
    if (frame_sync !== 1'b0 || serial_clk !== 1'b0) begin
      fails++;
      $display("FAIL %s_sync: FrameSync=%b SerialClk=%b expected 0 0", name, frame_sync, serial_clk);
    end
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1;
    data  = '0;
    @(posedge clk); #1;
    check_idle("reset");
    reset = 1'b0;
    send_frame("first_frame_zero", '0, -1, '0);
  endtask

  task automatic test_patterns();
    send_frame("pat_101", 24'h000065, -1, '0);
    send_frame("pat_msb", 24'h800000, -1, '0);
  endtask

  task automatic test_input_change();
    send_frame("hold_12d", 24'h00012D, 10, 24'hFFFFFF);
    send_frame("all_ones", 24'hFFFFFF, -1, '0);
  endtask

  task automatic test_reset_mid_frame();
    data = 24'hAAAAAA;
    push_frame(data);
    // Bit 10 starts at frame clock (DW-1-10)*CPB.
    for (int i = 0; i < int'((DW - 11) * CPB); i++) begin
      @(posedge clk); #1;
      check_cycle("abort_pre", i);
    end
    exp_q.delete();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_idle("abort_reset");
    end
    reset = 1'b0;
    send_frame("abort_restart", 24'hAAAAAA, -1, '0);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 4; n++) send_frame("b2b", dac_sample_t'($urandom), -1, '0);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: size=%0d expected 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_patterns();
    test_input_change();
    test_reset_mid_frame();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
